// File: rtl/load_store_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : load_store_unit                                               |
// | Desc     : Single-outstanding load/store unit bridging the core to a     |
// |            req/gnt/rvalid word bus with byte lanes and load extension.   |
// | Option   : LSU_MISALIGN_TRAP_EN - misaligned half/word accesses fault    |
// |            instead of being silently aligned.                            |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+

module load_store_unit (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [2:0]  mem_control,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic        bus_gnt,
    input  logic        bus_rvalid,
    input  logic [31:0] bus_rdata
);

    localparam logic [2:0] c_lb  = 3'b000;
    localparam logic [2:0] c_lh  = 3'b001;
    localparam logic [2:0] c_lw  = 3'b010;
    localparam logic [2:0] c_lbu = 3'b011;
    localparam logic [2:0] c_lhu = 3'b100;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_REQ    = 2'd1,
        S_WAIT_R = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t r_state;
    state_t w_next;

    logic        w_strobe;
    logic        w_is_byte;
    logic        w_is_half;
    logic        w_is_word;
    logic        w_fault;
    logic [31:0] w_eff_addr;
    logic [3:0]  w_be;
    logic [31:0] w_wdata;

    logic        r_err;
    logic        r_byte;
    logic        r_half;
    logic        r_unsigned;
    logic [1:0]  r_lane;
    logic [7:0]  w_byte_val;
    logic [15:0] w_half_val;
    logic [31:0] w_load;

    assign w_strobe  = mem_read | mem_write;
    assign w_is_byte = (mem_control == c_lb) | (mem_control == c_lbu);
    assign w_is_half = (mem_control == c_lh) | (mem_control == c_lhu);
    assign w_is_word = (mem_control == c_lw);

`ifdef LSU_MISALIGN_TRAP_EN
    logic w_misaligned;
    assign w_misaligned = (w_is_half & addr[0]) | (w_is_word & (|addr[1:0]));
    assign w_fault      = (mem_read & mem_write) | (mem_control > c_lhu) | w_misaligned;
    assign w_eff_addr   = addr;
`else
    // Misaligned half/word accesses drop their low address bits.
    assign w_fault    = (mem_read & mem_write) | (mem_control > c_lhu);
    assign w_eff_addr = {addr[31:2],
                         w_is_word ? 2'b00 : (w_is_half ? {addr[1], 1'b0} : addr[1:0])};
`endif

    assign w_be    = w_is_byte ? (4'b0001 << w_eff_addr[1:0]) :
                     w_is_half ? (4'b0011 << {w_eff_addr[1], 1'b0}) : 4'b1111;
    assign w_wdata = w_is_byte ? {4{wdata[7:0]}} :
                     w_is_half ? {2{wdata[15:0]}} : wdata;

    assign w_byte_val = bus_rdata[{r_lane, 3'b000} +: 8];
    assign w_half_val = r_lane[1] ? bus_rdata[31:16] : bus_rdata[15:0];
    assign w_load     = r_byte ? {{24{~r_unsigned & w_byte_val[7]}}, w_byte_val} :
                        r_half ? {{16{~r_unsigned & w_half_val[15]}}, w_half_val} :
                                 bus_rdata;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (w_strobe) w_next = w_fault ? S_DONE : S_REQ;
            S_REQ:    if (bus_gnt) w_next = bus_we ? S_DONE : S_WAIT_R;
            S_WAIT_R: if (bus_rvalid) w_next = S_DONE;
            S_DONE:   w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rdata      <= 32'd0;
            bus_req    <= 1'b0;
            bus_we     <= 1'b0;
            bus_addr   <= 32'd0;
            bus_be     <= 4'd0;
            bus_wdata  <= 32'd0;
            r_err      <= 1'b0;
            r_byte     <= 1'b0;
            r_half     <= 1'b0;
            r_unsigned <= 1'b0;
            r_lane     <= 2'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_strobe) begin
                        r_err <= w_fault;
                        if (!w_fault) begin
                            bus_req    <= 1'b1;
                            bus_we     <= mem_write;
                            bus_addr   <= {w_eff_addr[31:2], 2'b00};
                            bus_be     <= w_be;
                            bus_wdata  <= w_wdata;
                            r_byte     <= w_is_byte;
                            r_half     <= w_is_half;
                            r_unsigned <= (mem_control == c_lbu) | (mem_control == c_lhu);
                            r_lane     <= w_eff_addr[1:0];
                        end
                    end
                end
                S_REQ: begin
                    if (bus_gnt) bus_req <= 1'b0;
                end
                S_WAIT_R: begin
                    if (bus_rvalid) rdata <= w_load;
                end
                default: begin
                end
            endcase
        end
    end

    assign done = (r_state == S_DONE);
    assign err  = done & r_err;
    assign busy = ((r_state == S_IDLE) & w_strobe) | (r_state == S_REQ) | (r_state == S_WAIT_R);

endmodule

`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_load_store_unit                                            |
// | Desc     : Self-checking bench for load_store_unit with a byte-level     |
// |            reference model of lane selection and load extension.        |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+

module tb_load_store_unit;

`ifdef LSU_MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic        mem_read;
    logic        mem_write;
    logic [2:0]  mem_control;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        busy;
    logic        done;
    logic        err;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic        bus_gnt;
    logic        bus_rvalid;
    logic [31:0] bus_rdata;

    int checks   = 0;
    int failures = 0;

    logic [31:0] exp_rdata;
    logic [3:0]  obs_be;
    logic [31:0] obs_wd;
    logic [31:0] obs_addr;
    logic        obs_err;

    load_store_unit dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .mem_read    (mem_read),
        .mem_write   (mem_write),
        .mem_control (mem_control),
        .addr        (addr),
        .wdata       (wdata),
        .rdata       (rdata),
        .busy        (busy),
        .done        (done),
        .err         (err),
        .bus_req     (bus_req),
        .bus_we      (bus_we),
        .bus_addr    (bus_addr),
        .bus_be      (bus_be),
        .bus_wdata   (bus_wdata),
        .bus_gnt     (bus_gnt),
        .bus_rvalid  (bus_rvalid),
        .bus_rdata   (bus_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives one request through the bus handshake and checks every cycle
    // against a model built from access size in bytes and byte offset.
    task automatic run_txn(input bit rd, input bit wr, input logic [2:0] code,
                           input logic [31:0] a, input logic [31:0] wd,
                           input int gdly, input int rdly,
                           input logic [31:0] rword, input bit junk_rv);
        int unsigned n;
        bit          fault;
        logic [31:0] ea;
        logic [31:0] wd_exp;
        logic [31:0] ld;
        logic [31:0] mask;
        logic [3:0]  be_exp;

        n = (code == 3'd0 || code == 3'd3) ? 1 :
            (code == 3'd1 || code == 3'd4) ? 2 : (code == 3'd2) ? 4 : 0;
        fault = (rd && wr) || (n == 0);
        ea = a;
        if (!fault) begin
            if ((a % n) != 0) begin
                if (TRAP) fault = 1'b1;
                else ea = a - (a % n);
            end
        end
        be_exp = 4'(((32'd1 << n) - 1) << (ea % 4));
        wd_exp = 32'd0;
        if (!fault) begin
            for (int i = 0; i < 4; i++) wd_exp[8*i +: 8] = wd[8*(i % n) +: 8];
        end
        ld = rword >> (8 * (ea % 4));
        if (!fault && n < 4) begin
            mask = (32'd1 << (8 * n)) - 1;
            ld = ld & mask;
            if ((code == 3'd0 || code == 3'd1) && ld[8*n-1]) ld = ld | ~mask;
        end

        mem_read = rd; mem_write = wr; mem_control = code; addr = a; wdata = wd;
        bus_gnt = 1'b0; bus_rvalid = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b1) begin
            failures++; $display("FAIL busy_on_request: got %b want 1", busy);
        end
        tick();

        if (fault) begin
            obs_err = err;
            checks++;
            if ({done, err, bus_req, busy} !== 4'b1100) begin
                failures++;
                $display("FAIL fault_response {done,err,req,busy}: got %b want 1100",
                         {done, err, bus_req, busy});
            end
            checks++;
            if (rdata !== exp_rdata) begin
                failures++; $display("FAIL fault_rdata_hold: got %h want %h", rdata, exp_rdata);
            end
            mem_read = 1'b0; mem_write = 1'b0;
            tick();
            checks++;
            if ({done, err, bus_req} !== 3'b000) begin
                failures++; $display("FAIL fault_after: got %b want 000", {done, err, bus_req});
            end
            return;
        end

        obs_be = bus_be; obs_wd = bus_wdata; obs_addr = bus_addr; obs_err = 1'b0;
        checks++;
        if ({bus_req, bus_we, bus_addr, bus_be, done, busy} !==
            {1'b1, wr, ea & ~32'd3, be_exp, 1'b0, 1'b1}) begin
            failures++;
            $display("FAIL req_phase {req,we,addr,be,done,busy}: got %b %b %h %b %b %b want 1 %b %h %b 0 1",
                     bus_req, bus_we, bus_addr, bus_be, done, busy, wr, ea & ~32'd3, be_exp);
        end
        if (wr) begin
            checks++;
            if (bus_wdata !== wd_exp) begin
                failures++; $display("FAIL store_wdata: got %h want %h", bus_wdata, wd_exp);
            end
        end

        for (int k = 0; k < gdly; k++) begin
            bus_rvalid = junk_rv; bus_rdata = $urandom;
            tick();
            checks++;
            if ({bus_req, bus_addr, bus_be, bus_wdata, done} !==
                {1'b1, obs_addr, obs_be, obs_wd, 1'b0}) begin
                failures++;
                $display("FAIL req_hold cycle %0d: got req=%b addr=%h be=%b done=%b",
                         k, bus_req, bus_addr, bus_be, done);
            end
        end

        bus_gnt = 1'b1; bus_rvalid = junk_rv; bus_rdata = $urandom;
        tick();
        bus_gnt = 1'b0; bus_rvalid = 1'b0;

        if (wr) begin
            checks++;
            if ({done, err, busy, bus_req} !== 4'b1000 || rdata !== exp_rdata) begin
                failures++;
                $display("FAIL store_done {done,err,busy,req}: got %b rdata=%h want 1000 rdata=%h",
                         {done, err, busy, bus_req}, rdata, exp_rdata);
            end
        end else begin
            checks++;
            if ({done, busy, bus_req} !== 3'b010) begin
                failures++;
                $display("FAIL wait_r {done,busy,req}: got %b want 010", {done, busy, bus_req});
            end
            for (int k = 0; k < rdly; k++) begin
                bus_rdata = $urandom;
                tick();
                checks++;
                if ({done, busy} !== 2'b01) begin
                    failures++; $display("FAIL wait_r_hold: got %b want 01", {done, busy});
                end
            end
            bus_rvalid = 1'b1; bus_rdata = rword;
            tick();
            bus_rvalid = 1'b0; bus_rdata = $urandom;
            exp_rdata = ld;
            checks++;
            if ({done, err, busy} !== 3'b100 || rdata !== exp_rdata) begin
                failures++;
                $display("FAIL load_done {done,err,busy}: got %b rdata=%h want 100 rdata=%h",
                         {done, err, busy}, rdata, exp_rdata);
            end
        end

        mem_read = 1'b0; mem_write = 1'b0;
        tick();
        checks++;
        if ({done, err, busy, bus_req} !== 4'b0000) begin
            failures++;
            $display("FAIL idle_after: got %b want 0000", {done, err, busy, bus_req});
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        checks++;
        if ({rdata, busy, done, err, bus_req, bus_we, bus_be, bus_addr, bus_wdata} !== '0) begin
            failures++;
            $display("FAIL reset_state: got rdata=%h busy=%b done=%b err=%b req=%b we=%b be=%b addr=%h wd=%h want all zero",
                     rdata, busy, done, err, bus_req, bus_we, bus_be, bus_addr, bus_wdata);
        end
        rst_n = 1'b1;
        tick();
        checks++;
        if ({busy, done, bus_req} !== 3'b000) begin
            failures++; $display("FAIL reset_release: got %b want 000", {busy, done, bus_req});
        end
        exp_rdata = 32'd0;
    endtask

    task automatic test_store_word();
        run_txn(1'b0, 1'b1, 3'b010, 32'h100, 32'hDEADBEEF, 0, 0, 32'h0, 1'b0);
        checks++;
        if ({obs_be, obs_wd, obs_addr} !== {4'b1111, 32'hDEADBEEF, 32'h100}) begin
            failures++;
            $display("FAIL sw_bus: got be=%b wd=%h addr=%h want 1111 deadbeef 00000100",
                     obs_be, obs_wd, obs_addr);
        end
    endtask

    task automatic test_load_byte();
        run_txn(1'b1, 1'b0, 3'b000, 32'h203, 32'h0, 1, 0, 32'h80FF1234, 1'b1);
        checks++;
        if (obs_be !== 4'b1000 || rdata !== 32'hFFFFFF80) begin
            failures++; $display("FAIL lb: got be=%b rdata=%h want 1000 ffffff80", obs_be, rdata);
        end
        run_txn(1'b1, 1'b0, 3'b011, 32'h203, 32'h0, 0, 1, 32'h80FF1234, 1'b0);
        checks++;
        if (rdata !== 32'h00000080) begin
            failures++; $display("FAIL lbu: got rdata=%h want 00000080", rdata);
        end
    endtask

    task automatic test_half();
        run_txn(1'b0, 1'b1, 3'b001, 32'h12, 32'h0000ABCD, 0, 0, 32'h0, 1'b0);
        checks++;
        if (obs_be !== 4'b1100 || obs_wd !== 32'hABCDABCD) begin
            failures++; $display("FAIL sh: got be=%b wd=%h want 1100 abcdabcd", obs_be, obs_wd);
        end
        run_txn(1'b1, 1'b0, 3'b001, 32'h12, 32'h0, 0, 0, 32'h80010000, 1'b0);
        checks++;
        if (rdata !== 32'hFFFF8001) begin
            failures++; $display("FAIL lh: got rdata=%h want ffff8001", rdata);
        end
    endtask

    task automatic test_misalign();
        run_txn(1'b1, 1'b0, 3'b010, 32'h101, 32'h0, 0, 0, 32'hA5A50F0F, 1'b0);
        checks++;
        if (TRAP) begin
            if (obs_err !== 1'b1) begin
                failures++; $display("FAIL lw_misalign_trap: got err=%b want 1", obs_err);
            end
        end else begin
            if ({obs_addr, obs_be, rdata} !== {32'h100, 4'b1111, 32'hA5A50F0F}) begin
                failures++;
                $display("FAIL lw_misalign_align: got addr=%h be=%b rdata=%h want 00000100 1111 a5a50f0f",
                         obs_addr, obs_be, rdata);
            end
        end
    endtask

    task automatic test_illegal();
        run_txn(1'b1, 1'b1, 3'b010, 32'h40, 32'h1, 0, 0, 32'h0, 1'b0);
        checks++;
        if (obs_err !== 1'b1) begin
            failures++; $display("FAIL both_strobes: got err=%b want 1", obs_err);
        end
        run_txn(1'b1, 1'b0, 3'b101, 32'h40, 32'h0, 0, 0, 32'h0, 1'b0);
        checks++;
        if (obs_err !== 1'b1) begin
            failures++; $display("FAIL code_101_load: got err=%b want 1", obs_err);
        end
        run_txn(1'b0, 1'b1, 3'b111, 32'h44, 32'h5, 0, 0, 32'h0, 1'b0);
        checks++;
        if (obs_err !== 1'b1) begin
            failures++; $display("FAIL code_111_store: got err=%b want 1", obs_err);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] held;
        run_txn(1'b1, 1'b0, 3'b010, 32'h300, 32'h0, 0, 0, 32'h13572468, 1'b0);
        held = 32'h13572468;
        run_txn(1'b0, 1'b1, 3'b000, 32'h301, 32'h000000C3, 0, 0, 32'h0, 1'b0);
        run_txn(1'b0, 1'b1, 3'b100, 32'h302, 32'h00009876, 2, 0, 32'h0, 1'b1);
        checks++;
        if (rdata !== held) begin
            failures++; $display("FAIL rdata_hold_over_stores: got %h want %h", rdata, held);
        end
    endtask

    task automatic test_random();
        for (int t = 0; t < 60; t++) begin
            int          sel;
            logic [2:0]  code;
            sel  = $urandom_range(0, 9);
            code = 3'($urandom_range(0, 9) > 7 ? 2 : $urandom_range(0, 7));
            run_txn(sel <= 5, sel == 0 || sel > 5, code, $urandom, $urandom,
                    $urandom_range(0, 3), $urandom_range(0, 2), $urandom,
                    1'($urandom_range(0, 1)));
        end
    endtask

    task automatic test_reset_mid();
        run_txn(1'b1, 1'b0, 3'b010, 32'h80, 32'h0, 0, 0, 32'h12345678, 1'b0);

        // Reset while waiting for grant.
        mem_read = 1'b1; mem_control = 3'b010; addr = 32'h84;
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1; mem_read = 1'b0;
        #1;
        checks++;
        if ({bus_req, done, busy} !== 3'b000) begin
            failures++; $display("FAIL reset_in_req: got %b want 000", {bus_req, done, busy});
        end
        tick();

        // Stalled grant, then reset in WAIT_R.
        mem_read = 1'b1; mem_control = 3'b010; addr = 32'h88;
        tick();
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++;
            if ({bus_req, bus_addr, bus_be} !== {1'b1, 32'h88, 4'b1111}) begin
                failures++;
                $display("FAIL stall_hold %0d: got req=%b addr=%h be=%b", k, bus_req, bus_addr, bus_be);
            end
        end
        bus_gnt = 1'b1;
        tick();
        bus_gnt = 1'b0;
        checks++;
        if ({busy, bus_req} !== 2'b10) begin
            failures++; $display("FAIL stall_grant: got %b want 10", {busy, bus_req});
        end
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1; mem_read = 1'b0;
        #1;
        exp_rdata = 32'd0;
        checks++;
        if ({rdata, busy, done, err, bus_req, bus_we, bus_be, bus_addr, bus_wdata} !== '0) begin
            failures++;
            $display("FAIL reset_in_wait_r: got rdata=%h busy=%b done=%b req=%b be=%b addr=%h",
                     rdata, busy, done, bus_req, bus_be, bus_addr);
        end
        bus_rvalid = 1'b1; bus_rdata = 32'hCAFEBABE;
        tick();
        bus_rvalid = 1'b0;
        tick();
        checks++;
        if ({done, rdata} !== {1'b0, 32'd0}) begin
            failures++; $display("FAIL late_rvalid: got done=%b rdata=%h want 0 00000000", done, rdata);
        end
    endtask

    initial begin
        rst_n = 1'b0; mem_read = 1'b0; mem_write = 1'b0; mem_control = 3'b000;
        addr = 32'd0; wdata = 32'd0; bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_rdata = 32'd0;
        exp_rdata = 32'd0; obs_be = 4'd0; obs_wd = 32'd0; obs_addr = 32'd0; obs_err = 1'b0;
        test_reset();
        test_store_word();
        test_load_byte();
        test_half();
        test_misalign();
        test_illegal();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule

`default_nettype wire
